// File: rtl/alu_retire.sv
// alu_retire: retire stage sitting directly behind the combinational ALU.
//
// Purpose:
//   Captures the ALU result, flags and penalty count when an operation is
//   issued, holds the operation for its modelled wait cycles, then offers it
//   to register/flag writeback over a valid/ready handshake. This keeps
//   multi-cycle shifts/rotates cycle-accurate without the ALU holding state.
//
// Configuration:
//   NEC_ALU_WAIT_EN  defined   -> penalty count = min(alu_cycles + EXTRA_WAIT, 63)
//                    undefined -> count forced to 0, every op retires after 1 cycle
//
// Parameters:
//   EXTRA_WAIT   wait cycles added to every operation (0..63)
//   flags_t      type of the ALU flag bundle
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   flush                     synchronous abort of any held operation
//   in_valid / in_ready       issue handshake
//   alu_result, alu_cycles,
//   alu_flags                 ALU outputs captured on accept
//   in_wide, in_pair, in_dest,
//   in_flags_we               operation attributes captured on accept
//   out_valid / out_ready     writeback handshake
//   out_result, out_dest, out_wide, out_pair,
//   out_flags, out_flags_we   captured operation presented to writeback
//   busy                      stage is holding an operation
module alu_retire #(
  parameter int unsigned EXTRA_WAIT = 0,
  parameter type flags_t = logic [5:0]
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [5:0]  alu_cycles,
  input  flags_t      alu_flags,
  input  logic        in_wide,
  input  logic        in_pair,
  input  logic [2:0]  in_dest,
  input  logic        in_flags_we,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_dest,
  output logic        out_wide,
  output logic        out_pair,
  output flags_t      out_flags,
  output logic        out_flags_we,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [5:0]  loadCount;
  logic [31:0] maskedResult;
  logic        accept;

  logic [31:0] result_q;
  logic [2:0]  dest_q;
  logic        wide_q;
  logic        pair_q;
  flags_t      flags_q;
  logic        flagsWe_q;

  // Penalty count loaded on accept. With the wait feature compiled in, the
  // ALU penalty plus the fixed extra wait is saturated at 63 so it fits the
  // 6-bit counter; otherwise every operation is presented straight away.
`ifdef NEC_ALU_WAIT_EN
  logic [6:0] waitSum;
  assign waitSum   = {1'b0, alu_cycles} + 7'(EXTRA_WAIT);
  assign loadCount = (waitSum > 7'd63) ? 6'd63 : waitSum[5:0];
`else
  logic unusedWaitInputs;
  assign unusedWaitInputs = ^{alu_cycles, 6'(EXTRA_WAIT)};
  assign loadCount        = 6'd0;
`endif

  // Result masking happens at capture time so writeback only ever sees the
  // bits the operation really produced. A byte MUL still yields a 16-bit
  // product, so pair without wide keeps the low half-word.
  always_comb begin
    maskedResult = {24'h0, alu_result[7:0]};
    if (in_pair && in_wide) begin
      maskedResult = alu_result;
    end else if (in_pair || in_wide) begin
      maskedResult = {16'h0, alu_result[15:0]};
    end
  end

  // A new operation can enter when empty, or when the held one is leaving
  // this very cycle, which gives back-to-back throughput through HOLD.
  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept   = in_valid && in_ready && !flush;

  // Next-state logic. Flush wins over everything, then a fresh accept, then
  // the count-down in WAIT and the handshake completion in HOLD.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (flush) begin
      state_d = IDLE;
      count_d = 6'd0;
    end else if (accept) begin
      count_d = loadCount;
      state_d = (loadCount == 6'd0) ? HOLD : WAIT;
    end else begin
      case (state_q)
        WAIT: begin
          count_d = count_q - 6'd1;
          if (count_q == 6'd1) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and counter registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= 6'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Captured operation. These only move on an accept so writeback sees a
  // stable payload for the whole time out_valid is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q  <= 32'h0;
      dest_q    <= 3'd0;
      wide_q    <= 1'b0;
      pair_q    <= 1'b0;
      flags_q   <= '0;
      flagsWe_q <= 1'b0;
    end else if (accept) begin
      result_q  <= maskedResult;
      dest_q    <= in_dest;
      wide_q    <= in_wide;
      pair_q    <= in_pair;
      flags_q   <= alu_flags;
      flagsWe_q <= in_flags_we;
    end
  end

  assign out_valid    = (state_q == HOLD);
  assign busy         = (state_q != IDLE);
  assign out_result   = result_q;
  assign out_dest     = dest_q;
  assign out_wide     = wide_q;
  assign out_pair     = pair_q;
  assign out_flags    = flags_q;
  assign out_flags_we = flagsWe_q;

endmodule
